sd_block_sequencer: RTL and testbench

Hardware sequencer that drives the SD controller register bus to fetch one 512-byte block into the SD read FIFO without SPI host involvement. It gates on FIFO free space, writes the LBA and the READ command, then polls STATUS until the controller finishes, errors, or times out. It sits between the playback engine (start/lba) and the SD register bus. While it owns the bus, `bus_own` steers the top-level mux away from the SPI link.

---
 rtl/sd_regs_pkg.sv | 44 ++++
 rtl/sd_block_sequencer_if.sv | 26 ++
 rtl/sd_block_sequencer_poll_timer.sv | 40 ++++
 rtl/sd_block_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sd_block_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_regs_pkg.sv
// SD controller register map, command/status encodings and sequencer types.
// Shared by the block sequencer and the SPI link.
package sd_regs_pkg;

   localparam logic [6:0] REG_LBA0   = 7'h00;
   localparam logic [6:0] REG_LBA1   = 7'h01;
   localparam logic [6:0] REG_LBA2   = 7'h02;
   localparam logic [6:0] REG_LBA3   = 7'h03;
   localparam logic [6:0] REG_CMD    = 7'h04;
   localparam logic [6:0] REG_STATUS = 7'h05;

   localparam logic [7:0] CMD_READ_BLOCK = 8'h01;

   localparam int STS_BUSY = 0;
   localparam int STS_ERR  = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ROOM,
      S_WR_LBA,
      S_WR_CMD,
      S_POLL_ADDR,
      S_POLL_CHECK,
      S_POLL_GAP,
      S_FINISH
   } seq_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CTRL    = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_code_t;

   // Address of the LBA byte register selected by a 2-bit byte index.
   function automatic logic [6:0] lba_reg(input logic [1:0] idx);
      case (idx)
         2'd0:    return REG_LBA0;
         2'd1:    return REG_LBA1;
         2'd2:    return REG_LBA2;
         default: return REG_LBA3;
      endcase
   endfunction

endpackage

// File: rtl/sd_block_sequencer_if.sv
// SD controller register bus as seen by whoever currently owns it.
interface sd_block_sequencer_if;

   logic       bus_own;
   logic [6:0] sd_addr;
   logic       sd_we;
   logic [7:0] sd_data_o;
   logic [7:0] sd_data_i;

   modport master (
      output bus_own,
      output sd_addr,
      output sd_we,
      output sd_data_o,
      input  sd_data_i
   );

   modport slave (
      input  bus_own,
      input  sd_addr,
      input  sd_we,
      input  sd_data_o,
      output sd_data_i
   );

endinterface

// File: rtl/sd_block_sequencer_poll_timer.sv
// Gap and poll counters for STATUS polling: tick ends an idle gap,
// expired flags that the current poll is the POLL_MAX-th one.
module sd_poll_timer #(
   parameter int POLL_GAP = 16,
   parameter int POLL_MAX = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic gap_en,
   input  logic poll_inc,
   output logic tick,
   output logic expired
);

   localparam int GAP_W = $clog2(POLL_GAP + 1);
   localparam int CNT_W = $clog2(POLL_MAX + 1);

   logic [GAP_W-1:0] gap_cnt;
   logic [CNT_W-1:0] poll_cnt;

   assign tick    = gap_en && (gap_cnt == GAP_W'(POLL_GAP - 1));
   assign expired = (poll_cnt == CNT_W'(POLL_MAX - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gap_cnt  <= '0;
         poll_cnt <= '0;
      end else if (clear) begin
         gap_cnt  <= '0;
         poll_cnt <= '0;
      end else begin
         if (gap_en)
            gap_cnt <= tick ? '0 : gap_cnt + 1'b1;
         if (poll_inc)
            poll_cnt <= poll_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sd_block_sequencer.sv
// Fetches one block into the SD read FIFO by writing LBA and READ to the
// SD controller, then polling STATUS until done, error or timeout.
module sd_block_sequencer
   import sd_regs_pkg::*;
#(
   parameter int BLOCK_BYTES = 512,
   parameter int RD_LAT      = 1,
   parameter int POLL_GAP    = 16,
   parameter int POLL_MAX    = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] lba,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   input  logic [9:0]  fifo_free,
   sd_block_sequencer_if.master bus
);

   localparam logic [9:0] ROOM_MIN = 10'(BLOCK_BYTES);
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   seq_state_t state, state_nxt;
   err_code_t  err_q, err_val;

   logic [31:0] lba_q;
   logic [1:0]  byte_idx;
   logic [1:0]  lat_cnt;
   logic [6:0]  addr_q, addr_nxt;
   logic [7:0]  data_q, data_nxt;
   logic        we, own;
   logic        accept, err_set, poll_inc, gap_en;
   logic        tick, expired;

   sd_poll_timer #(
      .POLL_GAP (POLL_GAP),
      .POLL_MAX (POLL_MAX)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .gap_en   (gap_en),
      .poll_inc (poll_inc),
      .tick     (tick),
      .expired  (expired)
   );

   // Address and write data fall back to their held copies whenever the
   // current state does not drive the bus.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      we        = 1'b0;
      own       = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      accept    = 1'b0;
      err_set   = 1'b0;
      err_val   = ERR_NONE;
      poll_inc  = 1'b0;
      gap_en    = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_WAIT_ROOM;
            end
         end
         S_WAIT_ROOM: begin
            busy = 1'b1;
            if (fifo_free >= ROOM_MIN)
               state_nxt = S_WR_LBA;
         end
         S_WR_LBA: begin
            busy     = 1'b1;
            own      = 1'b1;
            we       = 1'b1;
            addr_nxt = lba_reg(byte_idx);
            data_nxt = lba_q[{byte_idx, 3'b000} +: 8];
            if (byte_idx == 2'd3)
               state_nxt = S_WR_CMD;
         end
         S_WR_CMD: begin
            busy      = 1'b1;
            own       = 1'b1;
            we        = 1'b1;
            addr_nxt  = REG_CMD;
            data_nxt  = CMD_READ_BLOCK;
            state_nxt = S_POLL_ADDR;
         end
         S_POLL_ADDR: begin
            busy     = 1'b1;
            own      = 1'b1;
            addr_nxt = REG_STATUS;
            if (lat_cnt == LAT_LAST)
               state_nxt = S_POLL_CHECK;
         end
         S_POLL_CHECK: begin
            busy     = 1'b1;
            own      = 1'b1;
            addr_nxt = REG_STATUS;
            // A controller error wins even when BUSY has already cleared.
            if (bus.sd_data_i[STS_ERR]) begin
               err_set   = 1'b1;
               err_val   = ERR_CTRL;
               state_nxt = S_FINISH;
            end else if (!bus.sd_data_i[STS_BUSY]) begin
               state_nxt = S_FINISH;
            end else begin
               poll_inc = 1'b1;
               if (expired) begin
                  err_set   = 1'b1;
                  err_val   = ERR_TIMEOUT;
                  state_nxt = S_FINISH;
               end else begin
                  state_nxt = S_POLL_GAP;
               end
            end
         end
         S_POLL_GAP: begin
            busy   = 1'b1;
            own    = 1'b1;
            gap_en = 1'b1;
            if (tick)
               state_nxt = S_POLL_ADDR;
         end
         S_FINISH: begin
            done      = (err_q == ERR_NONE);
            err       = (err_q != ERR_NONE);
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         lba_q    <= '0;
         err_q    <= ERR_NONE;
         byte_idx <= '0;
         lat_cnt  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state  <= state_nxt;
         addr_q <= addr_nxt;
         data_q <= data_nxt;
         if (accept) begin
            lba_q    <= lba;
            err_q    <= ERR_NONE;
            byte_idx <= '0;
            lat_cnt  <= '0;
         end else begin
            if (err_set)
               err_q <= err_val;
            if (state == S_WR_LBA)
               byte_idx <= byte_idx + 1'b1;
            if (state == S_POLL_ADDR)
               lat_cnt <= (lat_cnt == LAT_LAST) ? '0 : lat_cnt + 1'b1;
         end
      end
   end

   assign err_code      = err_q;
   assign bus.bus_own   = own;
   assign bus.sd_we     = we;
   assign bus.sd_addr   = addr_nxt;
   assign bus.sd_data_o = data_nxt;

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer: a vector table of whole block fetches
// plus hand-written FIFO-gate, mid-write reset and start-collision sequences.
module tb_sd_block_sequencer;
   import sd_regs_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] lba = '0;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [9:0]  fifo_free = '0;

   sd_block_sequencer_if bus ();

   sd_block_sequencer #(
      .BLOCK_BYTES (512),
      .RD_LAT      (1),
      .POLL_GAP    (16),
      .POLL_MAX    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .lba       (lba),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .fifo_free (fifo_free),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lba;
      logic [9:0]  fifo;
      int          n_busy;
      logic [7:0]  final_sts;
      logic        exp_done;
      logic [1:0]  exp_code;
      int          exp_lat;
   } vec_t;

   vec_t        vecs [6];
   int          compared = 0;
   int          mismatched = 0;
   int          tx_cyc = 0;
   int          busy_until = 0;
   logic [7:0]  final_sts = '0;
   logic [6:0]  prev_addr = '0;
   int          wr_n = 0;
   logic [6:0]  wr_addr [16];
   logic [7:0]  wr_data [16];
   int          own_viol = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // STATUS responder returns data one cycle after the address it saw.
   task automatic stepCycle();
      @(negedge clk);
      tx_cyc++;
      if (bus.sd_we) begin
         if (!bus.bus_own)
            own_viol++;
         if (wr_n < 16) begin
            wr_addr[wr_n] = bus.sd_addr;
            wr_data[wr_n] = bus.sd_data_o;
         end
         wr_n++;
      end
      bus.sd_data_i = (prev_addr == REG_STATUS) ?
                      (((tx_cyc - 1) < busy_until) ? 8'h01 : final_sts) : 8'h00;
      prev_addr = bus.sd_addr;
   endtask

   task automatic beginTx(input logic [31:0] a, input logic [9:0] ff, input int bu, input logic [7:0] fs);
      stepCycle();
      for (int i = 0; i < 16; i++) begin
         wr_addr[i] = '1;
         wr_data[i] = '1;
      end
      wr_n       = 0;
      fifo_free  = ff;
      busy_until = bu;
      final_sts  = fs;
      lba        = a;
      start      = 1'b1;
      tx_cyc     = 0;
   endtask

   task automatic waitEnd(input int limit, output int lat, output logic d, output logic e);
      lat = -1;
      d   = 1'b0;
      e   = 1'b0;
      for (int n = 0; n < limit; n++) begin
         stepCycle();
         start = 1'b0;
         if (done || err) begin
            lat = tx_cyc;
            d   = done;
            e   = err;
            break;
         end
      end
   endtask

   task automatic checkWrites(input string tag, input logic [31:0] a);
      logic [7:0] exp_byte;
      checkOutput({tag, "_wr_count"}, wr_n, 5);
      for (int i = 0; i < 5; i++) begin
         exp_byte = (i < 4) ? a[8*i +: 8] : 8'h01;
         checkOutput($sformatf("%s_wr%0d", tag, i), {wr_addr[i], wr_data[i]}, {7'(i), exp_byte});
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int    bu, lat;
      logic  d, e;
      string tag;
      tag = $sformatf("vec%0d", idx);
      bu  = (v.n_busy >= 99) ? 1000000 : ((v.n_busy == 0) ? 0 : 18 * v.n_busy - 2);
      beginTx(v.lba, v.fifo, bu, v.final_sts);
      waitEnd(200, lat, d, e);
      checkOutput({tag, "_latency"}, lat, v.exp_lat);
      checkOutput({tag, "_done"}, d, v.exp_done);
      checkOutput({tag, "_err"}, e, !v.exp_done);
      checkOutput({tag, "_err_code"}, err_code, v.exp_code);
      checkOutput({tag, "_busy_finish"}, busy, 0);
      checkOutput({tag, "_own_finish"}, bus.bus_own, 0);
      checkWrites(tag, v.lba);
      stepCycle();
      checkOutput({tag, "_pulse_after"}, {done, err}, 0);
      checkOutput({tag, "_code_held"}, err_code, v.exp_code);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   quiet, busy_low, lat, pulses, busy_after, own_cnt;
      logic d, e;

      vecs[0] = '{32'hA1B2C3D4, 10'd600,  0,  8'h00, 1'b1, 2'd0, 9};
      vecs[1] = '{32'h12345678, 10'd512,  3,  8'h00, 1'b1, 2'd0, 63};
      vecs[2] = '{32'hDEADBEEF, 10'd1023, 0,  8'h03, 1'b0, 2'd1, 9};
      vecs[3] = '{32'h00000000, 10'd700,  99, 8'h01, 1'b0, 2'd2, 63};
      vecs[4] = '{32'hFFFFFFFF, 10'd512,  1,  8'h02, 1'b0, 2'd1, 27};
      vecs[5] = '{32'h80000001, 10'd513,  2,  8'h03, 1'b0, 2'd1, 45};

      bus.sd_data_i = 8'h00;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_err_code", err_code, 0);
      checkOutput("rst_bus_own", bus.bus_own, 0);
      checkOutput("rst_sd_addr", bus.sd_addr, 0);
      checkOutput("rst_sd_we", bus.sd_we, 0);
      checkOutput("rst_sd_data_o", bus.sd_data_o, 0);
      rst = 1'b1;

      for (int i = 0; i < 6; i++)
         applyStimulus(vecs[i], i);

      // FIFO gate: 100 then 511 bytes free must stall, 512 releases.
      beginTx(32'h0BADF00D, 10'd100, 0, 8'h00);
      quiet    = 0;
      busy_low = 0;
      for (int n = 0; n < 50; n++) begin
         stepCycle();
         start = 1'b0;
         if (bus.sd_we || bus.bus_own)
            quiet++;
         if (!busy)
            busy_low++;
         if (tx_cyc == 25)
            fifo_free = 10'd511;
      end
      fifo_free = 10'd512;
      waitEnd(100, lat, d, e);
      checkOutput("gate_quiet", quiet, 0);
      checkOutput("gate_busy_low", busy_low, 0);
      checkOutput("gate_latency", lat, 58);
      checkOutput("gate_done", d, 1);
      checkWrites("gate", 32'h0BADF00D);

      // Reset during the second LBA write aborts without further bus cycles.
      beginTx(32'h11223344, 10'd600, 0, 8'h00);
      stepCycle();
      start = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("abort_second_write", {bus.sd_we, bus.sd_addr, bus.sd_data_o}, {1'b1, 7'h01, 8'h33});
      rst = 1'b0;
      #1;
      checkOutput("abort_outputs", {busy, done, err, err_code, bus.bus_own, bus.sd_addr, bus.sd_we, bus.sd_data_o}, 0);
      stepCycle();
      stepCycle();
      rst  = 1'b1;
      wr_n = 0;
      own_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         stepCycle();
         if (bus.bus_own || busy)
            own_cnt++;
      end
      checkOutput("abort_no_writes", wr_n, 0);
      checkOutput("abort_idle", own_cnt, 0);
      applyStimulus(vecs[0], 6);

      // Start while busy and during FINISH must both be ignored.
      beginTx(32'hCAFEF00D, 10'd600, 0, 8'h00);
      pulses     = 0;
      busy_after = 0;
      lat        = -1;
      for (int n = 0; n < 40; n++) begin
         stepCycle();
         start = 1'b0;
         if (tx_cyc == 4) begin
            start = 1'b1;
            lba   = 32'h55555555;
         end
         if (done || err) begin
            pulses++;
            if (lat < 0) begin
               lat   = tx_cyc;
               start = 1'b1;
               lba   = 32'h66666666;
            end
         end else if (lat >= 0 && busy) begin
            busy_after++;
         end
      end
      checkOutput("collide_pulses", pulses, 1);
      checkOutput("collide_latency", lat, 9);
      checkOutput("collide_busy_after", busy_after, 0);
      checkWrites("collide", 32'hCAFEF00D);

      checkOutput("we_without_own", own_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
